// File: rtl/cdc_pkg.sv
// Shared helpers for the Gray-pointer FIFO: pointer width and Gray/binary conversion.
// Pointers up to 11 bits wide (DEPTH_LOG2 up to 10) are carried in ptr_t and sized down by the user.
package cdc_pkg;

   localparam int PTR_MAX_W = 11;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   function automatic int ptr_width(input int depth_log2);
      return depth_log2 + 1;
   endfunction

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended inputs convert correctly because the unused upper bits are zero.
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchronizer for a Gray-coded bus; only one bit changes per source update.
module cdc_sync_bus #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/cdc_gray_fifo.sv
// Dual-clock first-word-fall-through FIFO with Gray-coded pointer crossing.
// Levels on each side are pessimistic because they use the delayed view of the other pointer.
module cdc_gray_fifo
   import cdc_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DEPTH_LOG2  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AF_THRESH   = (1 << DEPTH_LOG2) - 4,
   parameter int AE_THRESH   = 2
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  wput,
   output logic                  wrdy,
   output logic [DEPTH_LOG2:0]   wlevel,
   output logic                  walmost_full,
   output logic                  woverflow,
   input  logic                  rclk,
   input  logic                  rrst_n,
   output logic [WIDTH-1:0]      rdata,
   output logic                  rrdy,
   input  logic                  rget,
   output logic [DEPTH_LOG2:0]   rlevel,
   output logic                  ralmost_empty
);

   localparam int PW    = ptr_width(DEPTH_LOG2);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
   localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0] wbin, wgray, wbin_next, rgray_wsync, rsync_bin;
   logic          w_live, wfull, wpush;
   logic [PW-1:0] rbin, rgray, rbin_next, wgray_rsync, wsync_bin;
   logic          rempty, rpop;

   // Write domain: w_live holds wrdy low until the first clock after reset release.
   assign wfull        = (wgray == {~rgray_wsync[PW-1:PW-2], rgray_wsync[PW-3:0]});
   assign wrdy         = w_live && !wfull;
   assign wpush        = wput && wrdy;
   assign wbin_next    = wbin + PW'(1);
   assign rsync_bin    = PW'(gray2bin(ptr_t'(rgray_wsync)));
   assign wlevel       = wbin - rsync_bin;
   assign walmost_full = (wlevel >= AF_LVL);

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin      <= '0;
         wgray     <= '0;
         w_live    <= 1'b0;
         woverflow <= 1'b0;
      end else begin
         w_live <= 1'b1;
         if (wpush) begin
            wbin  <= wbin_next;
            wgray <= PW'(bin2gray(ptr_t'(wbin_next)));
         end
         if (wput && !wrdy) begin
            woverflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge wclk) begin
      if (wpush) begin
         mem[wbin[DEPTH_LOG2-1:0]] <= wdata;
      end
   end

   cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_r2w (
      .clk   (wclk),
      .rst_n (wrst_n),
      .d     (rgray),
      .q     (rgray_wsync)
   );

   cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_sync_w2r (
      .clk   (rclk),
      .rst_n (rrst_n),
      .d     (wgray),
      .q     (wgray_rsync)
   );

   assign rempty        = (rgray == wgray_rsync);
   assign rrdy          = !rempty;
   assign rpop          = rget && rrdy;
   assign rbin_next     = rbin + PW'(1);
   assign wsync_bin     = PW'(gray2bin(ptr_t'(wgray_rsync)));
   assign rlevel        = wsync_bin - rbin;
   assign ralmost_empty = (rlevel <= AE_LVL);
   assign rdata         = mem[rbin[DEPTH_LOG2-1:0]];

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin  <= '0;
         rgray <= '0;
      end else if (rpop) begin
         rbin  <= rbin_next;
         rgray <= PW'(bin2gray(ptr_t'(rbin_next)));
      end
   end

endmodule

// File: tb/tb_cdc_gray_fifo.sv
// Self-checking bench for cdc_gray_fifo: reset, latency, fill/drain table, streaming and reset corners.
`timescale 1ns/1ps
module tb_cdc_gray_fifo;

   logic       wclk   = 1'b0;
   logic       rclk   = 1'b0;
   logic       wrst_n = 1'b1;
   logic       rrst_n = 1'b1;
   logic [7:0] wdata  = '0;
   logic       wput   = 1'b0;
   logic       rget   = 1'b0;
   logic       wrdy, walmost_full, woverflow;
   logic [4:0] wlevel, rlevel;
   logic [7:0] rdata;
   logic       rrdy, ralmost_empty;

   int wHalf = 5;
   int rHalf = 3;

   always #(wHalf) wclk = ~wclk;
   always #(rHalf) rclk = ~rclk;

   cdc_gray_fifo dut (
      .wclk          (wclk),
      .wrst_n        (wrst_n),
      .wdata         (wdata),
      .wput          (wput),
      .wrdy          (wrdy),
      .wlevel        (wlevel),
      .walmost_full  (walmost_full),
      .woverflow     (woverflow),
      .rclk          (rclk),
      .rrst_n        (rrst_n),
      .rdata         (rdata),
      .rrdy          (rrdy),
      .rget          (rget),
      .rlevel        (rlevel),
      .ralmost_empty (ralmost_empty)
   );

   typedef struct {
      logic       put;
      logic [7:0] data;
      logic       expRdy;
      logic [4:0] expLevel;
      logic       expAf;
      logic       expOvf;
   } fillVec_t;

   fillVec_t   fillTab [17];
   logic [7:0] expQ [$];
   int         checks   = 0;
   int         failures = 0;
   int         maxWlevel = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic popCompare(input string name);
      if (expQ.size() == 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected nothing (scoreboard empty)", name, rdata);
      end else begin
         checkOutput(name, 32'(rdata), 32'(expQ.pop_front()));
      end
   endtask

   task automatic resetBoth();
      wput = 1'b0;
      rget = 1'b0;
      #1;
      wrst_n = 1'b0;
      rrst_n = 1'b0;
      repeat (8) @(negedge wclk);
      expQ.delete();
      checkOutput("rst_wrdy", 32'(wrdy), 32'(0));
      checkOutput("rst_wlevel", 32'(wlevel), 32'(0));
      checkOutput("rst_walmost_full", 32'(walmost_full), 32'(0));
      checkOutput("rst_woverflow", 32'(woverflow), 32'(0));
      checkOutput("rst_rrdy", 32'(rrdy), 32'(0));
      checkOutput("rst_rlevel", 32'(rlevel), 32'(0));
      checkOutput("rst_ralmost_empty", 32'(ralmost_empty), 32'(1));
      @(negedge rclk);
      rrst_n = 1'b1;
      @(negedge wclk);
      wrst_n = 1'b1;
      checkOutput("rst_release_wrdy_low", 32'(wrdy), 32'(0));
      @(posedge wclk);
      #1;
      checkOutput("rst_wrdy_first_rise", 32'(wrdy), 32'(1));
   endtask

   task automatic writeOne(input logic [7:0] data, output logic accepted);
      @(negedge wclk);
      wdata    = data;
      wput     = 1'b1;
      accepted = wrdy;
      if (accepted) expQ.push_back(data);
      @(posedge wclk);
      #1;
      wput = 1'b0;
   endtask

   task automatic applyStimulus(input fillVec_t v);
      @(negedge wclk);
      wput  = v.put;
      wdata = v.data;
      if (v.put && wrdy) expQ.push_back(v.data);
      @(posedge wclk);
      #1;
      wput = 1'b0;
   endtask

   task automatic waitRrdy(input int bound, output int n);
      n = 0;
      while (!rrdy && n < bound) begin
         @(posedge rclk);
         #1;
         n++;
      end
   endtask

   task automatic runStream(input int n, input logic randomGet, input string tag);
      int sent;
      int got;
      int wcyc;
      int rcyc;
      sent = 0;
      got  = 0;
      wcyc = 0;
      rcyc = 0;
      fork
         begin
            while (sent < n && wcyc < 5000) begin
               @(negedge wclk);
               wcyc++;
               if (int'(wlevel) > maxWlevel) maxWlevel = int'(wlevel);
               wdata = 8'($urandom);
               wput  = 1'b1;
               if (wrdy) begin
                  expQ.push_back(wdata);
                  sent++;
               end
            end
            @(posedge wclk);
            #1;
            wput = 1'b0;
         end
         begin
            while (got < n && rcyc < 5000) begin
               @(negedge rclk);
               rcyc++;
               if (rrdy && (!randomGet || $urandom_range(0, 3) != 0)) begin
                  popCompare({tag, "_data"});
                  rget = 1'b1;
                  got++;
               end else begin
                  rget = 1'b0;
               end
            end
            @(posedge rclk);
            #1;
            rget = 1'b0;
         end
      join
      checkOutput({tag, "_sent"}, 32'(sent), 32'(n));
      checkOutput({tag, "_received"}, 32'(got), 32'(n));
   endtask

   initial begin
      logic acc;
      int   n;

      for (int k = 0; k < 16; k++) begin
         fillTab[k].put      = 1'b1;
         fillTab[k].data     = 8'(8'h40 + k);
         fillTab[k].expRdy   = (k + 1 < 16);
         fillTab[k].expLevel = 5'(k + 1);
         fillTab[k].expAf    = (k + 1 >= 12);
         fillTab[k].expOvf   = 1'b0;
      end
      fillTab[16].put      = 1'b1;
      fillTab[16].data     = 8'hEE;
      fillTab[16].expRdy   = 1'b0;
      fillTab[16].expLevel = 5'd16;
      fillTab[16].expAf    = 1'b1;
      fillTab[16].expOvf   = 1'b1;

      // Basic single-word transfer and read-side latency.
      resetBoth();
      writeOne(8'h11, acc);
      checkOutput("basic_accepted", 32'(acc), 32'(1));
      waitRrdy(3, n);
      checkOutput("basic_rrdy_rise", 32'(rrdy), 32'(1));
      popCompare("basic_rdata");
      @(negedge rclk);
      rget = 1'b1;
      @(posedge rclk);
      #1;
      rget = 1'b0;
      checkOutput("basic_rrdy_fall", 32'(rrdy), 32'(0));
      repeat (6) @(negedge wclk);
      checkOutput("basic_wlevel_back", 32'(wlevel), 32'(0));

      // Fill to full and one dropped write.
      for (int k = 0; k < 17; k++) begin
         applyStimulus(fillTab[k]);
         checkOutput($sformatf("fill_wrdy_%0d", k), 32'(wrdy), 32'(fillTab[k].expRdy));
         checkOutput($sformatf("fill_wlevel_%0d", k), 32'(wlevel), 32'(fillTab[k].expLevel));
         checkOutput($sformatf("fill_walmost_full_%0d", k), 32'(walmost_full), 32'(fillTab[k].expAf));
         checkOutput($sformatf("fill_woverflow_%0d", k), 32'(woverflow), 32'(fillTab[k].expOvf));
      end

      // Drain everything back in write order.
      repeat (6) @(negedge rclk);
      checkOutput("drain_start_wrdy", 32'(wrdy), 32'(0));
      for (int i = 0; i < 16; i++) begin
         checkOutput($sformatf("drain_rrdy_%0d", i), 32'(rrdy), 32'(1));
         checkOutput($sformatf("drain_rlevel_%0d", i), 32'(rlevel), 32'(16 - i));
         checkOutput($sformatf("drain_ralmost_empty_%0d", i), 32'(ralmost_empty), 32'((16 - i) <= 2));
         popCompare($sformatf("drain_data_%0d", i));
         rget = 1'b1;
         @(posedge rclk);
         #1;
         rget = 1'b0;
         if (i == 0) begin
            n = 0;
            while (!wrdy && n < 4) begin
               @(posedge wclk);
               #1;
               n++;
            end
            checkOutput("drain_wrdy_rise", 32'(wrdy && n <= 3), 32'(1));
         end
         @(negedge rclk);
      end
      checkOutput("drain_end_rrdy", 32'(rrdy), 32'(0));
      checkOutput("drain_end_rlevel", 32'(rlevel), 32'(0));
      checkOutput("drain_end_ralmost_empty", 32'(ralmost_empty), 32'(1));
      rget = 1'b1;
      @(posedge rclk);
      #1;
      rget = 1'b0;
      @(negedge rclk);
      checkOutput("extra_get_rrdy", 32'(rrdy), 32'(0));
      checkOutput("extra_get_rlevel", 32'(rlevel), 32'(0));
      checkOutput("drain_scoreboard_empty", 32'(expQ.size()), 32'(0));
      repeat (6) @(negedge wclk);

      // Continuous streaming across several pointer wraps.
      runStream(100, 1'b0, "wrap");
      checkOutput("wrap_scoreboard_empty", 32'(expQ.size()), 32'(0));

      // Faster writer than reader with a random read pattern.
      wHalf = 3;
      rHalf = 5;
      resetBoth();
      maxWlevel = 0;
      runStream(50, 1'b1, "swap");
      checkOutput("swap_max_wlevel_le_16", 32'(maxWlevel <= 16), 32'(1));
      checkOutput("swap_scoreboard_empty", 32'(expQ.size()), 32'(0));

      // Reset while holding data, then a clean restart.
      for (int i = 0; i < 7; i++) writeOne(8'(8'h70 + i), acc);
      repeat (6) @(negedge rclk);
      checkOutput("midop_rlevel_before", 32'(rlevel), 32'(7));
      resetBoth();
      writeOne(8'hA5, acc);
      waitRrdy(6, n);
      checkOutput("midop_rrdy", 32'(rrdy), 32'(1));
      checkOutput("midop_rlevel", 32'(rlevel), 32'(1));
      popCompare("midop_rdata");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
